// File: rtl/regfile_sequencer.sv
// regfile_sequencer: expands one register-transfer command at a time into
// register-file strobe/select cycles, and sequences the ALU handshake.
//
// Ports:
//   CLK, RST                    clock (rising edge), async active-high reset
//   CMD_VALID / CMD_READY       command handshake; CMD_READY only in idle
//   CMD_OP, CMD_SRC, CMD_SRC2,  opcode (0 NOP, 1 MOV, 2 ALU, 3 INC, 4 AXFER,
//   CMD_DST                     5 SWAP, 6-7 reserved) and register indices
//   ALU_GO / ALU_DONE / ALU_OE  ALU start pulse, result valid, result drive
//   DONE / ERR / BUSY           completion pulses and busy status
//   *_bar, ADDR_INC             register-file strobes (active-low / high)
//   *_SEL                       register-file selects, held while idle
//
// All outputs are registered: the comb block computes the outputs of the
// next cycle, so the first control cycle directly follows acceptance.
module regfile_sequencer #(
  parameter int unsigned SCRATCH_REG = 7,
  parameter int unsigned ALU_TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [2:0] CMD_OP,
  input  logic [2:0] CMD_SRC,
  input  logic [2:0] CMD_SRC2,
  input  logic [2:0] CMD_DST,
  output logic       ALU_GO,
  input  logic       ALU_DONE,
  output logic       ALU_OE,
  output logic       DONE,
  output logic       ERR,
  output logic       BUSY,
  output logic       MAIN_ASSERT_bar,
  output logic       MAIN_LOAD_bar,
  output logic       LHS_ASSERT_bar,
  output logic       RHS_ASSERT_bar,
  output logic       ADDR_ASSERT_bar,
  output logic       ADDR_LOAD_bar,
  output logic       ADDR_INC,
  output logic [2:0] MAIN_ASSERT_SEL,
  output logic [2:0] MAIN_LOAD_SEL,
  output logic [2:0] LHS_ASSERT_SEL,
  output logic [2:0] RHS_ASSERT_SEL,
  output logic [2:0] ADDR_ASSERT_SEL,
  output logic [2:0] ADDR_LOAD_SEL,
  output logic [2:0] ADDR_INC_SEL
);

  localparam logic [2:0] ScratchIdx = 3'(SCRATCH_REG);
  localparam logic [7:0] TimeoutCnt = 8'(ALU_TIMEOUT);

  localparam logic [2:0] OpNop   = 3'd0;
  localparam logic [2:0] OpMov   = 3'd1;
  localparam logic [2:0] OpAlu   = 3'd2;
  localparam logic [2:0] OpInc   = 3'd3;
  localparam logic [2:0] OpAxfer = 3'd4;
  localparam logic [2:0] OpSwap  = 3'd5;

  // StLast is the single DONE/ERR cycle shared by every command.
  typedef enum logic [2:0] {StIdle, StSwap1, StSwap2, StAlu1, StAluWait, StLast} state_e;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       done;
    logic       err;
    logic       alu_go;
    logic       alu_oe;
    logic       main_assert_n;
    logic       main_load_n;
    logic       lhs_assert_n;
    logic       rhs_assert_n;
    logic       addr_assert_n;
    logic       addr_load_n;
    logic       addr_inc;
    logic [2:0] main_assert_sel;
    logic [2:0] main_load_sel;
    logic [2:0] lhs_assert_sel;
    logic [2:0] rhs_assert_sel;
    logic [2:0] addr_assert_sel;
    logic [2:0] addr_load_sel;
    logic [2:0] addr_inc_sel;
  } ctrl_t;

  localparam ctrl_t CtrlReset = '{
    ready: 1'b1, busy: 1'b0, done: 1'b0, err: 1'b0, alu_go: 1'b0, alu_oe: 1'b0,
    main_assert_n: 1'b1, main_load_n: 1'b1, lhs_assert_n: 1'b1, rhs_assert_n: 1'b1,
    addr_assert_n: 1'b1, addr_load_n: 1'b1, addr_inc: 1'b0,
    main_assert_sel: 3'd0, main_load_sel: 3'd0, lhs_assert_sel: 3'd0,
    rhs_assert_sel: 3'd0, addr_assert_sel: 3'd0, addr_load_sel: 3'd0, addr_inc_sel: 3'd0
  };

  state_e     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] src_q, src_d;
  logic [2:0] dst_q, dst_d;
  logic       swap_bad;

  assign swap_bad = (CMD_SRC == CMD_DST) || (CMD_SRC == ScratchIdx) || (CMD_DST == ScratchIdx);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    src_d   = src_q;
    dst_d   = dst_q;
    // Selects hold by default; strobes and pulses fall back to inactive.
    ctrl_d               = ctrl_q;
    ctrl_d.done          = 1'b0;
    ctrl_d.err           = 1'b0;
    ctrl_d.alu_go        = 1'b0;
    ctrl_d.alu_oe        = 1'b0;
    ctrl_d.main_assert_n = 1'b1;
    ctrl_d.main_load_n   = 1'b1;
    ctrl_d.lhs_assert_n  = 1'b1;
    ctrl_d.rhs_assert_n  = 1'b1;
    ctrl_d.addr_assert_n = 1'b1;
    ctrl_d.addr_load_n   = 1'b1;
    ctrl_d.addr_inc      = 1'b0;

    case (state_q)
      StIdle: begin
        if (CMD_VALID && ctrl_q.ready) begin
          src_d   = CMD_SRC;
          dst_d   = CMD_DST;
          state_d = StLast;
          case (CMD_OP)
            OpNop: ctrl_d.done = 1'b1;
            OpMov: begin
              ctrl_d.main_assert_n   = 1'b0;
              ctrl_d.main_assert_sel = CMD_SRC;
              ctrl_d.main_load_n     = 1'b0;
              ctrl_d.main_load_sel   = CMD_DST;
              ctrl_d.done            = 1'b1;
            end
            OpAlu: begin
              ctrl_d.lhs_assert_n   = 1'b0;
              ctrl_d.lhs_assert_sel = CMD_SRC;
              ctrl_d.rhs_assert_n   = 1'b0;
              ctrl_d.rhs_assert_sel = CMD_SRC2;
              ctrl_d.alu_go         = 1'b1;
              state_d               = StAlu1;
            end
            OpInc: begin
              ctrl_d.addr_inc     = 1'b1;
              ctrl_d.addr_inc_sel = CMD_DST;
              ctrl_d.done         = 1'b1;
            end
            OpAxfer: begin
              ctrl_d.addr_assert_n   = 1'b0;
              ctrl_d.addr_assert_sel = CMD_SRC;
              ctrl_d.addr_load_n     = 1'b0;
              ctrl_d.addr_load_sel   = CMD_DST;
              ctrl_d.done            = 1'b1;
            end
            OpSwap: begin
              if (swap_bad) begin
                ctrl_d.err = 1'b1;
              end else begin
                ctrl_d.main_assert_n   = 1'b0;
                ctrl_d.main_assert_sel = CMD_SRC;
                ctrl_d.main_load_n     = 1'b0;
                ctrl_d.main_load_sel   = ScratchIdx;
                state_d                = StSwap1;
              end
            end
            default: ctrl_d.err = 1'b1;
          endcase
        end
      end
      StSwap1: begin
        ctrl_d.main_assert_n   = 1'b0;
        ctrl_d.main_assert_sel = dst_q;
        ctrl_d.main_load_n     = 1'b0;
        ctrl_d.main_load_sel   = src_q;
        state_d                = StSwap2;
      end
      StSwap2: begin
        ctrl_d.main_assert_n   = 1'b0;
        ctrl_d.main_assert_sel = ScratchIdx;
        ctrl_d.main_load_n     = 1'b0;
        ctrl_d.main_load_sel   = dst_q;
        ctrl_d.done            = 1'b1;
        state_d                = StLast;
      end
      StAlu1: begin
        // ALU_DONE is deliberately not looked at during the GO cycle.
        ctrl_d.lhs_assert_n = 1'b0;
        ctrl_d.rhs_assert_n = 1'b0;
        state_d             = StAluWait;
      end
      StAluWait: begin
        cnt_d = cnt_q + 8'd1;
        if (ALU_DONE) begin
          cnt_d                = '0;
          ctrl_d.main_load_n   = 1'b0;
          ctrl_d.main_load_sel = dst_q;
          ctrl_d.alu_oe        = 1'b1;
          ctrl_d.done          = 1'b1;
          state_d              = StLast;
        end else if (cnt_d == TimeoutCnt) begin
          cnt_d      = '0;
          ctrl_d.err = 1'b1;
          state_d    = StLast;
        end else begin
          ctrl_d.lhs_assert_n = 1'b0;
          ctrl_d.rhs_assert_n = 1'b0;
        end
      end
      StLast:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    ctrl_d.ready = (state_d == StIdle);
    ctrl_d.busy  = (state_d != StIdle);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      ctrl_q  <= CtrlReset;
      cnt_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
    end
  end

  assign CMD_READY       = ctrl_q.ready;
  assign BUSY            = ctrl_q.busy;
  assign DONE            = ctrl_q.done;
  assign ERR             = ctrl_q.err;
  assign ALU_GO          = ctrl_q.alu_go;
  assign ALU_OE          = ctrl_q.alu_oe;
  assign MAIN_ASSERT_bar = ctrl_q.main_assert_n;
  assign MAIN_LOAD_bar   = ctrl_q.main_load_n;
  assign LHS_ASSERT_bar  = ctrl_q.lhs_assert_n;
  assign RHS_ASSERT_bar  = ctrl_q.rhs_assert_n;
  assign ADDR_ASSERT_bar = ctrl_q.addr_assert_n;
  assign ADDR_LOAD_bar   = ctrl_q.addr_load_n;
  assign ADDR_INC        = ctrl_q.addr_inc;
  assign MAIN_ASSERT_SEL = ctrl_q.main_assert_sel;
  assign MAIN_LOAD_SEL   = ctrl_q.main_load_sel;
  assign LHS_ASSERT_SEL  = ctrl_q.lhs_assert_sel;
  assign RHS_ASSERT_SEL  = ctrl_q.rhs_assert_sel;
  assign ADDR_ASSERT_SEL = ctrl_q.addr_assert_sel;
  assign ADDR_LOAD_SEL   = ctrl_q.addr_load_sel;
  assign ADDR_INC_SEL    = ctrl_q.addr_inc_sel;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: per-cycle expected records are queued when a
// command is driven and popped/compared one per cycle afterwards.
module tb_regfile_sequencer;

  logic       CLK, RST, CMD_VALID, CMD_READY, ALU_GO, ALU_DONE, ALU_OE, DONE, ERR, BUSY;
  logic [2:0] CMD_OP, CMD_SRC, CMD_SRC2, CMD_DST;
  logic       MAIN_ASSERT_bar, MAIN_LOAD_bar, LHS_ASSERT_bar, RHS_ASSERT_bar;
  logic       ADDR_ASSERT_bar, ADDR_LOAD_bar, ADDR_INC;
  logic [2:0] MAIN_ASSERT_SEL, MAIN_LOAD_SEL, LHS_ASSERT_SEL, RHS_ASSERT_SEL;
  logic [2:0] ADDR_ASSERT_SEL, ADDR_LOAD_SEL, ADDR_INC_SEL;

  regfile_sequencer #(.SCRATCH_REG(7), .ALU_TIMEOUT(15)) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_SRC(CMD_SRC), .CMD_SRC2(CMD_SRC2), .CMD_DST(CMD_DST),
    .ALU_GO(ALU_GO), .ALU_DONE(ALU_DONE), .ALU_OE(ALU_OE), .DONE(DONE), .ERR(ERR),
    .BUSY(BUSY), .MAIN_ASSERT_bar(MAIN_ASSERT_bar), .MAIN_LOAD_bar(MAIN_LOAD_bar),
    .LHS_ASSERT_bar(LHS_ASSERT_bar), .RHS_ASSERT_bar(RHS_ASSERT_bar),
    .ADDR_ASSERT_bar(ADDR_ASSERT_bar), .ADDR_LOAD_bar(ADDR_LOAD_bar), .ADDR_INC(ADDR_INC),
    .MAIN_ASSERT_SEL(MAIN_ASSERT_SEL), .MAIN_LOAD_SEL(MAIN_LOAD_SEL),
    .LHS_ASSERT_SEL(LHS_ASSERT_SEL), .RHS_ASSERT_SEL(RHS_ASSERT_SEL),
    .ADDR_ASSERT_SEL(ADDR_ASSERT_SEL), .ADDR_LOAD_SEL(ADDR_LOAD_SEL),
    .ADDR_INC_SEL(ADDR_INC_SEL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic done, err, busy, ready, go, oe;
    logic ma_n, ml_n, lhs_n, rhs_n, aa_n, al_n, inc;
  } flags_t;

  // sel index: 0 main_assert, 1 main_load, 2 lhs, 3 rhs, 4 addr_assert, 5 addr_load, 6 addr_inc
  typedef struct {
    string            name;
    flags_t           f;
    logic [6:0][2:0]  s;
    logic [6:0]       m;
  } exp_t;

  typedef struct {
    logic [2:0] op, src, src2, dst;
    exp_t       e;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[10];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic exp_t idle_rec(string nm);
    exp_t e;
    e.name = nm;
    e.f = '{done: 1'b0, err: 1'b0, busy: 1'b0, ready: 1'b1, go: 1'b0, oe: 1'b0,
            ma_n: 1'b1, ml_n: 1'b1, lhs_n: 1'b1, rhs_n: 1'b1, aa_n: 1'b1, al_n: 1'b1,
            inc: 1'b0};
    e.s = '0;
    e.m = '0;
    return e;
  endfunction

  function automatic exp_t reset_rec(string nm);
    exp_t e = idle_rec(nm);
    e.m = 7'h7f;  // every select must read back as 0
    return e;
  endfunction

  function automatic exp_t busy_rec(string nm);
    exp_t e = idle_rec(nm);
    e.f.ready = 1'b0;
    e.f.busy  = 1'b1;
    return e;
  endfunction

  function automatic exp_t done_rec(string nm);
    exp_t e = busy_rec(nm);
    e.f.done = 1'b1;
    return e;
  endfunction

  function automatic exp_t err_rec(string nm);
    exp_t e = busy_rec(nm);
    e.f.err = 1'b1;
    return e;
  endfunction

  function automatic exp_t mov_rec(string nm, logic [2:0] a, logic [2:0] l, bit fin);
    exp_t e = busy_rec(nm);
    e.f.done = fin;
    e.f.ma_n = 1'b0; e.s[0] = a; e.m[0] = 1'b1;
    e.f.ml_n = 1'b0; e.s[1] = l; e.m[1] = 1'b1;
    return e;
  endfunction

  function automatic exp_t inc_rec(string nm, logic [2:0] d);
    exp_t e = done_rec(nm);
    e.f.inc = 1'b1; e.s[6] = d; e.m[6] = 1'b1;
    return e;
  endfunction

  function automatic exp_t axfer_rec(string nm, logic [2:0] a, logic [2:0] l);
    exp_t e = done_rec(nm);
    e.f.aa_n = 1'b0; e.s[4] = a; e.m[4] = 1'b1;
    e.f.al_n = 1'b0; e.s[5] = l; e.m[5] = 1'b1;
    return e;
  endfunction

  function automatic exp_t alu_rec(string nm, logic [2:0] l, logic [2:0] r, bit go);
    exp_t e = busy_rec(nm);
    e.f.go    = go;
    e.f.lhs_n = 1'b0; e.s[2] = l; e.m[2] = 1'b1;
    e.f.rhs_n = 1'b0; e.s[3] = r; e.m[3] = 1'b1;
    return e;
  endfunction

  function automatic exp_t wb_rec(string nm, logic [2:0] d);
    exp_t e = done_rec(nm);
    e.f.oe = 1'b1;
    e.f.ml_n = 1'b0; e.s[1] = d; e.m[1] = 1'b1;
    return e;
  endfunction

  function automatic vec_t mkv(logic [2:0] op, logic [2:0] src, logic [2:0] src2,
                               logic [2:0] dst, exp_t e);
    vec_t v;
    v.op = op; v.src = src; v.src2 = src2; v.dst = dst; v.e = e;
    return v;
  endfunction

  task automatic check(input exp_t e);
    flags_t          af;
    logic [6:0][2:0] as;
    bit              ok;
    af = {DONE, ERR, BUSY, CMD_READY, ALU_GO, ALU_OE, MAIN_ASSERT_bar, MAIN_LOAD_bar,
          LHS_ASSERT_bar, RHS_ASSERT_bar, ADDR_ASSERT_bar, ADDR_LOAD_bar, ADDR_INC};
    as = {ADDR_INC_SEL, ADDR_LOAD_SEL, ADDR_ASSERT_SEL, RHS_ASSERT_SEL, LHS_ASSERT_SEL,
          MAIN_LOAD_SEL, MAIN_ASSERT_SEL};
    ok = (af === e.f);
    for (int i = 0; i < 7; i++) begin
      if (e.m[i] && (as[i] !== e.s[i])) ok = 1'b0;
    end
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: flags got %b want %b, sels got %h want %h (mask %b) t=%0t",
                  e.name, af, e.f, as, e.s, e.m, $time);
  endtask

  // Issue one command from idle, then compare one queued record per cycle.
  // done_mask bit k drives ALU_DONE during record k; hold_valid keeps a MOV
  // offered while the command is in flight (it must not be taken).
  task automatic run_cmd(input logic [2:0] op, input logic [2:0] src, input logic [2:0] src2,
                         input logic [2:0] dst, input logic [31:0] done_mask,
                         input bit hold_valid);
    CMD_VALID = 1'b1; CMD_OP = op; CMD_SRC = src; CMD_SRC2 = src2; CMD_DST = dst;
    @(posedge CLK); #1;
    if (hold_valid) begin
      CMD_OP = 3'd1; CMD_SRC = 3'd0; CMD_DST = 3'd1;
    end
    for (int k = 0; exp_q.size() > 0; k++) begin
      CMD_VALID = hold_valid && (exp_q.size() > 1);
      ALU_DONE  = (k < 32) ? done_mask[k[4:0]] : 1'b0;
      check(exp_q.pop_front());
      @(posedge CLK); #1;
    end
    CMD_VALID = 1'b0;
    ALU_DONE  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; CMD_VALID = 1'b0; ALU_DONE = 1'b0;
    CMD_OP = '0; CMD_SRC = '0; CMD_SRC2 = '0; CMD_DST = '0;

    vecs[0] = mkv(3'd0, 3'd0, 3'd0, 3'd0, done_rec("nop"));
    vecs[1] = mkv(3'd1, 3'd2, 3'd0, 3'd5, mov_rec("mov_2_5", 3'd2, 3'd5, 1'b1));
    vecs[2] = mkv(3'd1, 3'd3, 3'd0, 3'd3, mov_rec("mov_3_3", 3'd3, 3'd3, 1'b1));
    vecs[3] = mkv(3'd3, 3'd0, 3'd0, 3'd6, inc_rec("inc_6", 3'd6));
    vecs[4] = mkv(3'd4, 3'd1, 3'd0, 3'd6, axfer_rec("axfer_1_6", 3'd1, 3'd6));
    vecs[5] = mkv(3'd6, 3'd1, 3'd2, 3'd3, err_rec("op6"));
    vecs[6] = mkv(3'd7, 3'd4, 3'd5, 3'd6, err_rec("op7"));
    vecs[7] = mkv(3'd5, 3'd7, 3'd0, 3'd3, err_rec("swap_src_scratch"));
    vecs[8] = mkv(3'd5, 3'd2, 3'd0, 3'd7, err_rec("swap_dst_scratch"));
    vecs[9] = mkv(3'd5, 3'd5, 3'd0, 3'd5, err_rec("swap_same"));

    repeat (2) @(posedge CLK);
    #1;
    check(reset_rec("reset_state"));
    RST = 1'b0;
    @(posedge CLK); #1;
    check(reset_rec("idle_after_reset"));

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].e);
      exp_q.push_back(idle_rec({vecs[i].e.name, "_ready"}));
      run_cmd(vecs[i].op, vecs[i].src, vecs[i].src2, vecs[i].dst, 32'h0, 1'b0);
    end

    // SWAP 1,3 through the scratch register
    exp_q.push_back(mov_rec("swap_s1", 3'd1, 3'd7, 1'b0));
    exp_q.push_back(mov_rec("swap_s2", 3'd3, 3'd1, 1'b0));
    exp_q.push_back(mov_rec("swap_s3", 3'd7, 3'd3, 1'b1));
    exp_q.push_back(idle_rec("swap_ready"));
    run_cmd(3'd5, 3'd1, 3'd0, 3'd3, 32'h0, 1'b0);

    // ALU 0,4 -> 6 with ALU_DONE during the third wait cycle
    exp_q.push_back(alu_rec("alu_a1", 3'd0, 3'd4, 1'b1));
    for (int k = 0; k < 3; k++) exp_q.push_back(alu_rec("alu_wait", 3'd0, 3'd4, 1'b0));
    exp_q.push_back(wb_rec("alu_wb", 3'd6));
    exp_q.push_back(idle_rec("alu_ready"));
    run_cmd(3'd2, 3'd0, 3'd4, 3'd6, 32'h8, 1'b0);

    // ALU_DONE in A1 is ignored; the one in the second wait cycle is taken
    exp_q.push_back(alu_rec("alu2_a1", 3'd3, 3'd5, 1'b1));
    for (int k = 0; k < 2; k++) exp_q.push_back(alu_rec("alu2_wait", 3'd3, 3'd5, 1'b0));
    exp_q.push_back(wb_rec("alu2_wb", 3'd1));
    exp_q.push_back(idle_rec("alu2_ready"));
    run_cmd(3'd2, 3'd3, 3'd5, 3'd1, 32'h5, 1'b0);

    // ALU timeout: 15 wait cycles then ERR, with a MOV offered throughout
    exp_q.push_back(alu_rec("alu_to_a1", 3'd1, 3'd2, 1'b1));
    for (int k = 0; k < 15; k++) exp_q.push_back(alu_rec("alu_to_wait", 3'd1, 3'd2, 1'b0));
    exp_q.push_back(err_rec("alu_to_err"));
    exp_q.push_back(idle_rec("alu_to_ready"));
    run_cmd(3'd2, 3'd1, 3'd2, 3'd3, 32'h0, 1'b1);

    // CMD_VALID held: INC 4, AXFER 4->5, OP 6; fields change while busy
    CMD_VALID = 1'b1; CMD_OP = 3'd3; CMD_SRC = 3'd0; CMD_DST = 3'd4;
    @(posedge CLK); #1;
    CMD_OP = 3'd4; CMD_SRC = 3'd4; CMD_DST = 3'd5;
    check(inc_rec("held_inc", 3'd4));
    @(posedge CLK); #1;
    check(idle_rec("held_gap1"));
    @(posedge CLK); #1;
    CMD_OP = 3'd6;
    check(axfer_rec("held_axfer", 3'd4, 3'd5));
    @(posedge CLK); #1;
    check(idle_rec("held_gap2"));
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    check(err_rec("held_op6"));
    @(posedge CLK); #1;
    check(idle_rec("held_ready"));

    // Reset asserted asynchronously during SWAP S2
    CMD_VALID = 1'b1; CMD_OP = 3'd5; CMD_SRC = 3'd0; CMD_DST = 3'd2;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    check(mov_rec("rst_swap_s1", 3'd0, 3'd7, 1'b0));
    @(posedge CLK); #1;
    check(mov_rec("rst_swap_s2", 3'd2, 3'd0, 1'b0));
    #2 RST = 1'b1;
    #1 check(reset_rec("rst_mid_swap"));
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    check(reset_rec("ready_after_rst"));

    exp_q.push_back(mov_rec("post_rst_mov", 3'd6, 3'd2, 1'b1));
    exp_q.push_back(idle_rec("post_rst_ready"));
    run_cmd(3'd1, 3'd6, 3'd0, 3'd2, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Command-driven controller that sequences the 8-entry register file's strobe and select lines.
- Accepts one register-transfer command at a time over a valid/ready handshake and expands it into one or more register-file control cycles.
- ALU commands use a request/done handshake with the external ALU.
- Sits between the instruction decoder and the register file.

Parameters:
- SCRATCH_REG, 7, register index used as temporary by SWAP; SWAP naming it is an error.
- ALU_TIMEOUT, 15, max cycles spent in ALU_WAIT before abort (range 1..255).

Ports:
- CLK  in  1  system clock, rising-edge.
- RST  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  sequencer can accept a command.
- CMD_OP  in  3  0 NOP, 1 MOV, 2 ALU, 3 INC, 4 AXFER, 5 SWAP, 6-7 reserved.
- CMD_SRC  in  3  source register.
- CMD_SRC2  in  3  second ALU operand register.
- CMD_DST  in  3  destination register.
- ALU_GO  out  1  one-cycle ALU start pulse.
- ALU_DONE  in  1  ALU result valid.
- ALU_OE  out  1  ALU drives result onto MAIN bus.
- DONE  out  1  one-cycle pulse, command finished OK.
- ERR  out  1  one-cycle pulse, command rejected or aborted.
- BUSY  out  1  high in any state but IDLE.
- MAIN_ASSERT_bar, MAIN_LOAD_bar, LHS_ASSERT_bar, RHS_ASSERT_bar, ADDR_ASSERT_bar, ADDR_LOAD_bar  out  1 each  register-file strobes, active-low.
- ADDR_INC  out  1  register-file address increment strobe, active-high.
- MAIN_ASSERT_SEL, MAIN_LOAD_SEL, LHS_ASSERT_SEL, RHS_ASSERT_SEL, ADDR_ASSERT_SEL, ADDR_LOAD_SEL, ADDR_INC_SEL  out  3 each  register-file selects.

Behaviour:
- Reset (async, any state): state IDLE, CMD_READY=1, all *_bar=1, ADDR_INC=0, ALU_GO=ALU_OE=DONE=ERR=BUSY=0, all selects=0, timeout counter=0.
- All outputs registered. A strobe is asserted for exactly one cycle. A select is valid in any cycle where its strobe is asserted and holds its value otherwise.
- Accept: rising edge with CMD_VALID=1 and CMD_READY=1 latches OP/SRC/SRC2/DST.
- CMD_READY=1 only in IDLE. CMD_VALID while busy is ignored. The first control cycle is the cycle immediately after acceptance.
- NOP: 1 cycle, no strobes, DONE.
- MOV: 1 cycle, MAIN_ASSERT sel=SRC + MAIN_LOAD sel=DST, DONE. SRC==DST is legal.
- INC: 1 cycle, ADDR_INC sel=DST, DONE.
- AXFER: 1 cycle, ADDR_ASSERT sel=SRC + ADDR_LOAD sel=DST, DONE.
- SWAP: 3 cycles, each a MOV:
  - S1: SCRATCH <- SRC.
  - S2: SRC <- DST.
  - S3: DST <- SCRATCH, DONE in S3.
  - SRC==DST, SRC==SCRATCH_REG or DST==SCRATCH_REG: no strobes, ERR in the first cycle, return to IDLE.
- ALU:
  - A1: LHS_ASSERT sel=SRC, RHS_ASSERT sel=SRC2, ALU_GO=1.
  - ALU_WAIT: LHS/RHS strobes held low, counter increments each cycle.
  - ALU_DONE=1 seen in ALU_WAIT: next cycle is WB with MAIN_LOAD sel=DST, ALU_OE=1, DONE. LHS/RHS deassert in WB.
  - ALU_DONE is ignored in A1.
  - Counter reaching ALU_TIMEOUT with no ALU_DONE: abort, deassert all strobes, ERR, no writeback.
- Reserved ops: 1 cycle, no strobes, ERR.
- After DONE/ERR cycle: back to IDLE, CMD_READY=1 the following cycle. Back-to-back commands therefore need at least one IDLE cycle between them.
- Never asserted simultaneously: DONE and ERR; MAIN_ASSERT_bar=0 and ALU_OE=1.
- Reset mid-command: strobes deassert immediately (async); no partial completion signalled.

Test Plan:
- Reset asserted mid-SWAP S2 -> all *_bar=1 and BUSY=0 within the same cycle; CMD_READY=1 after release.
- MOV SRC=2 DST=5 -> next cycle MAIN_ASSERT_bar=0 sel 2, MAIN_LOAD_bar=0 sel 5, DONE=1; CMD_READY back to 1 one cycle later.
- SWAP SRC=1 DST=3 -> three cycles with (assert,load) pairs (1,7), (3,1), (7,3); DONE only on the third. SWAP SRC=7 DST=3 -> ERR, no strobes.
- ALU SRC=0 SRC2=4 DST=6 with ALU_DONE raised 3 cycles after ALU_GO -> LHS/RHS low throughout the wait, WB cycle with MAIN_LOAD sel 6 and ALU_OE=1, DONE.
- ALU with ALU_DONE never raised, ALU_TIMEOUT=15 -> ERR after 15 wait cycles, MAIN_LOAD_bar never low.
- CMD_VALID held high with INC DST=4 then AXFER SRC=4 DST=5, OP 6 -> ADDR_INC sel 4, then ADDR_ASSERT/ADDR_LOAD 4/5, then ERR; extra commands while BUSY not accepted.
